// File: rtl/intc_pkg.sv
// Shared definitions for int_ctrl: register offsets, CLAIM valid-bit position, bus FSM states.
package intc_pkg;

  localparam logic [2:0] ADDR_PENDING = 3'd0;
  localparam logic [2:0] ADDR_MASK    = 3'd1;
  localparam logic [2:0] ADDR_CLAIM   = 3'd2;
  localparam logic [2:0] ADDR_CTRL    = 3'd3;
  localparam logic [2:0] ADDR_RAW     = 3'd4;

  localparam int CLAIM_VALID_BIT = 31;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } bus_state_e;

endpackage

// File: rtl/intc_prio_enc.sv
// Lowest-index-first priority encoder: o_id is the smallest set bit of i_req, o_valid when any bit is set.
module intc_prio_enc #(
  parameter int N = 8
) (
  input  logic [N-1:0] i_req,
  output logic         o_valid,
  output logic [3:0]   o_id
);

  // Scan high to low so the lowest set index is the last one assigned.
  always_comb begin
    o_valid = 1'b0;
    o_id    = 4'd0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_valid = 1'b1;
        o_id    = 4'(i);
      end
    end
  end

endmodule

// File: rtl/int_ctrl.sv
// Edge-triggered interrupt controller with PENDING/MASK/CLAIM/CTRL/RAW registers and a two-state bus handshake.
// Define INTC_SYNC_EN to put a 2-flop synchronizer on irq_src ahead of edge detection.
module int_ctrl
  import intc_pkg::*;
#(
  parameter int NUM_SRC = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic               bus_sel,
  input  logic               bus_we,
  input  logic [2:0]         bus_addr,
  input  logic [31:0]        bus_wdata,
  output logic [31:0]        bus_rdata,
  output logic               bus_ready,
  output logic               INT
);

  logic [NUM_SRC-1:0] r_hist;
  logic [NUM_SRC-1:0] w_cur;
  logic [NUM_SRC-1:0] w_raw;

`ifdef INTC_SYNC_EN
  localparam logic [1:0] WARM_CYCLES = 2'd3;
  logic [NUM_SRC-1:0] r_sync1;
  logic [NUM_SRC-1:0] r_sync2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_hist  <= '0;
    end else begin
      r_sync1 <= irq_src;
      r_sync2 <= r_sync1;
      r_hist  <= r_sync2;
    end
  end

  assign w_cur = r_sync2;
  assign w_raw = r_sync2;
`else
  localparam logic [1:0] WARM_CYCLES = 2'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_hist <= '0;
    else       r_hist <= irq_src;
  end

  assign w_cur = irq_src;
  assign w_raw = r_hist;
`endif

  // Edges count only once the history holds a real post-reset sample, so lines high at release stay quiet.
  logic [1:0]         r_warm;
  logic               w_armed;
  logic [NUM_SRC-1:0] w_edge;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         r_warm <= 2'd0;
    else if (!w_armed) r_warm <= r_warm + 2'd1;
  end

  assign w_armed = (r_warm == WARM_CYCLES);
  assign w_edge  = w_armed ? (w_cur & ~r_hist) : '0;

  logic [NUM_SRC-1:0] r_pending;
  logic [NUM_SRC-1:0] r_mask;
  logic               r_gie;
  logic               r_int;
  bus_state_e         r_state;
  logic [31:0]        r_rdata;

  logic [NUM_SRC-1:0] w_active;
  logic               w_claim_valid;
  logic [3:0]         w_claim_id;

  assign w_active = r_pending & r_mask;

  intc_prio_enc #(.N(NUM_SRC)) u_prio (
    .i_req   (w_active),
    .o_valid (w_claim_valid),
    .o_id    (w_claim_id)
  );

  logic               w_access;
  logic               w_wr;
  logic               w_rd;
  logic               w_claim;
  logic [31:0]        w_rd_data;
  logic [NUM_SRC-1:0] w_clr;
  logic               w_unused_wdata;

  assign w_access       = (r_state == ST_IDLE) && bus_sel;
  assign w_wr           = w_access && bus_we;
  assign w_rd           = w_access && !bus_we;
  assign w_claim        = w_rd && (bus_addr == ADDR_CLAIM) && w_claim_valid;
  assign w_unused_wdata = ^bus_wdata;

  always_comb begin
    w_rd_data = 32'd0;
    case (bus_addr)
      ADDR_PENDING: w_rd_data = 32'(r_pending);
      ADDR_MASK:    w_rd_data = 32'(r_mask);
      ADDR_CLAIM: begin
        if (w_claim_valid) begin
          w_rd_data[CLAIM_VALID_BIT] = 1'b1;
          w_rd_data[3:0]             = w_claim_id;
        end
      end
      ADDR_CTRL:    w_rd_data[0] = r_gie;
      ADDR_RAW:     w_rd_data = 32'(w_raw);
      default:      w_rd_data = 32'd0;
    endcase
  end

  always_comb begin
    w_clr = '0;
    if (w_wr && (bus_addr == ADDR_PENDING)) w_clr = bus_wdata[NUM_SRC-1:0];
    if (w_claim)                            w_clr = w_clr | (NUM_SRC'(1) << w_claim_id);
  end

  // New edges are OR-ed in after the clear, so a same-cycle edge wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pending <= '0;
      r_mask    <= '0;
      r_gie     <= 1'b0;
      r_int     <= 1'b0;
    end else begin
      r_pending <= (r_pending & ~w_clr) | w_edge;
      if (w_wr && (bus_addr == ADDR_MASK)) r_mask <= bus_wdata[NUM_SRC-1:0];
      if (w_wr && (bus_addr == ADDR_CTRL)) r_gie  <= bus_wdata[0];
      r_int <= r_gie & (|w_active);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_rdata <= 32'd0;
    end else if (r_state == ST_IDLE) begin
      if (bus_sel) begin
        r_state <= ST_RESP;
        r_rdata <= bus_we ? 32'd0 : w_rd_data;
      end
    end else begin
      r_state <= ST_IDLE;
      r_rdata <= 32'd0;
    end
  end

  assign bus_ready = (r_state == ST_RESP);
  assign bus_rdata = r_rdata;
  assign INT       = r_int;

endmodule

// File: tb/tb_int_ctrl.sv
// Self-checking bench for int_ctrl: directed scenarios with literal expectations plus randomized traffic
// compared every cycle against a behavioural model built from sampled-input history.
module tb_int_ctrl;

`ifdef INTC_SYNC_EN
  localparam int EDGE_LAT = 2;
  localparam int RAW_DLY  = 2;
  localparam int INT_LAT  = 4;
`else
  localparam int EDGE_LAT = 0;
  localparam int RAW_DLY  = 1;
  localparam int INT_LAT  = 2;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  irq_src;
  logic        bus_sel;
  logic        bus_we;
  logic [2:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ready;
  logic        INT;

  int_ctrl #(.NUM_SRC(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .irq_src   (irq_src),
    .bus_sel   (bus_sel),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_ready (bus_ready),
    .INT       (INT)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic chk_en = 1'b0;

  // Model state
  logic [7:0]  hist[$];
  int          cyc;
  logic [7:0]  m_pend;
  logic [7:0]  m_mask;
  logic        m_gie;
  logic        m_resp;
  logic        exp_int;
  logic        exp_ready;
  logic [31:0] exp_rdata;

  logic [31:0] rd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist = {};
    hist.push_back(8'h00);
    cyc       = 0;
    m_pend    = 8'h00;
    m_mask    = 8'h00;
    m_gie     = 1'b0;
    m_resp    = 1'b0;
    exp_int   = 1'b0;
    exp_ready = 1'b0;
    exp_rdata = 32'd0;
  endtask

  // Called at each rising edge with the inputs that edge sampled.
  task automatic model_update();
    logic [7:0]  edges;
    logic [7:0]  clr;
    logic [7:0]  raw;
    logic [31:0] rdv;
    int          j;
    int          k;
    if (reset) begin
      model_reset();
      return;
    end
    cyc++;
    hist.push_back(irq_src);
    j     = cyc - EDGE_LAT;
    edges = (j >= 2) ? (hist[j] & ~hist[j-1]) : 8'h00;
    k     = cyc - RAW_DLY;
    raw   = (k >= 0) ? hist[k] : 8'h00;
    clr   = 8'h00;
    exp_int = m_gie && ((m_pend & m_mask) != 8'h00);
    if (m_resp) begin
      m_resp    = 1'b0;
      exp_ready = 1'b0;
      exp_rdata = 32'd0;
    end else if (bus_sel) begin
      m_resp    = 1'b1;
      exp_ready = 1'b1;
      rdv       = 32'd0;
      if (bus_we) begin
        case (bus_addr)
          3'd0: clr    = bus_wdata[7:0];
          3'd1: m_mask = bus_wdata[7:0];
          3'd3: m_gie  = bus_wdata[0];
          default: ;
        endcase
      end else begin
        case (bus_addr)
          3'd0: rdv = {24'd0, m_pend};
          3'd1: rdv = {24'd0, m_mask};
          3'd2: begin
            for (int i = 0; i < 8; i++) begin
              if (rdv == 32'd0 && m_pend[i] && m_mask[i]) begin
                rdv    = 32'h8000_0000 | i;
                clr[i] = 1'b1;
              end
            end
          end
          3'd3: rdv = {31'd0, m_gie};
          3'd4: rdv = {24'd0, raw};
          default: rdv = 32'd0;
        endcase
      end
      exp_rdata = rdv;
    end else begin
      exp_ready = 1'b0;
      exp_rdata = 32'd0;
    end
    m_pend = (m_pend & ~clr) | edges;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_INT", {31'd0, INT}, {31'd0, exp_int});
      chk("cyc_bus_ready", {31'd0, bus_ready}, {31'd0, exp_ready});
      chk("cyc_bus_rdata", bus_rdata, exp_rdata);
    end
  end

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) tick();
  endtask

  task automatic bus_access(input logic we, input logic [2:0] addr, input logic [31:0] wd,
                            output logic [31:0] rdv);
    bus_sel   = 1'b1;
    bus_we    = we;
    bus_addr  = addr;
    bus_wdata = wd;
    tick();
    rdv       = bus_rdata;
    bus_sel   = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = 3'd0;
    bus_wdata = 32'd0;
    tick();
    $display("[TB] %s addr=%0d wdata=%h rdata=%h", we ? "WR" : "RD", addr, wd, rdv);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "timeout");
  end

  initial begin
    reset     = 1'b1;
    irq_src   = 8'hFF;
    bus_sel   = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = 3'd0;
    bus_wdata = 32'd0;
    model_reset();
    wait_cycles(3);
    chk_en = 1'b1;
    chk("reset_INT", {31'd0, INT}, 32'd0);
    chk("reset_ready", {31'd0, bus_ready}, 32'd0);
    reset = 1'b0;

    // Lines held high through reset release must not latch.
    wait_cycles(6);
    bus_access(1'b0, 3'd0, 32'd0, rd);
    chk("rst_pending_zero", rd, 32'h0000_0000);
    chk("rst_INT_zero", {31'd0, INT}, 32'd0);
    irq_src = 8'h00;
    wait_cycles(2);
    irq_src = 8'hFF;
    wait_cycles(6);
    bus_access(1'b0, 3'd0, 32'd0, rd);
    chk("toggle_pending_ff", rd, 32'h0000_00FF);
    irq_src = 8'h00;
    wait_cycles(6);
    bus_access(1'b1, 3'd0, 32'hFFFF_FFFF, rd);

    // Edge and priority.
    bus_access(1'b1, 3'd1, 32'h0000_000C, rd);
    bus_access(1'b1, 3'd3, 32'h0000_0001, rd);
    irq_src[3] = 1'b1; tick();
    irq_src[3] = 1'b0; tick();
    irq_src[2] = 1'b1; tick();
    irq_src[2] = 1'b0;
    wait_cycles(6);
    chk("prio_INT_high", {31'd0, INT}, 32'd1);
    bus_access(1'b0, 3'd2, 32'd0, rd);
    chk("claim_first", rd, 32'h8000_0002);
    chk("prio_INT_still_high", {31'd0, INT}, 32'd1);
    bus_access(1'b0, 3'd2, 32'd0, rd);
    chk("claim_second", rd, 32'h8000_0003);
    chk("prio_INT_low", {31'd0, INT}, 32'd0);
    bus_access(1'b0, 3'd2, 32'd0, rd);
    chk("claim_empty", rd, 32'h0000_0000);

    // Masked source latches without INT.
    bus_access(1'b1, 3'd1, 32'h0000_0000, rd);
    irq_src[5] = 1'b1; tick();
    irq_src[5] = 1'b0;
    wait_cycles(6);
    bus_access(1'b0, 3'd0, 32'd0, rd);
    chk("mask_pending_20", rd, 32'h0000_0020);
    chk("mask_INT_low", {31'd0, INT}, 32'd0);
    bus_access(1'b1, 3'd1, 32'h0000_0020, rd);
    chk("unmask_INT_high", {31'd0, INT}, 32'd1);
    bus_access(1'b0, 3'd1, 32'd0, rd);
    chk("mask_readback", rd, 32'h0000_0020);
    bus_access(1'b1, 3'd0, 32'h0000_0020, rd);

    // W1C colliding with a new edge on the same bit.
    irq_src[0] = 1'b1;
    wait_cycles(6);
    irq_src[0] = 1'b0;
    wait_cycles(6);
    bus_access(1'b0, 3'd0, 32'd0, rd);
    chk("coll_pre_pending", rd, 32'h0000_0001);
    irq_src[0] = 1'b1;
    wait_cycles(EDGE_LAT);
    bus_access(1'b1, 3'd0, 32'h0000_0001, rd);
    bus_access(1'b0, 3'd0, 32'd0, rd);
    chk("coll_pending_kept", rd, 32'h0000_0001);
    irq_src[0] = 1'b0;
    wait_cycles(6);
    bus_access(1'b1, 3'd0, 32'hFFFF_FFFF, rd);

    // Handshake with bus_sel held for 6 cycles, reading RAW.
    irq_src = 8'h5A;
    wait_cycles(6);
    bus_sel  = 1'b1;
    bus_we   = 1'b0;
    bus_addr = 3'd4;
    chk("hs_ready_c1", {31'd0, bus_ready}, 32'd0);
    for (int n = 2; n <= 7; n++) begin
      tick();
      if (n == 7) bus_sel = 1'b0;
      chk($sformatf("hs_ready_c%0d", n), {31'd0, bus_ready}, (n % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("hs_rdata_c%0d", n), bus_rdata, (n % 2 == 0) ? 32'h0000_005A : 32'd0);
    end
    $display("[TB] RD handshake burst addr=4 done");
    tick();
    irq_src = 8'h00;
    wait_cycles(6);
    bus_access(1'b1, 3'd0, 32'hFFFF_FFFF, rd);

    // Edge-to-INT latency.
    bus_access(1'b1, 3'd1, 32'h0000_0002, rd);
    bus_access(1'b1, 3'd3, 32'h0000_0001, rd);
    begin
      int lat;
      lat = 0;
      irq_src[1] = 1'b1;
      for (int n = 1; n <= 10; n++) begin
        tick();
        if (INT && lat == 0) lat = n;
      end
      chk("edge_to_INT_latency", lat, INT_LAT);
    end
    irq_src = 8'h00;
    wait_cycles(4);

    // Reset in the middle of a response.
    bus_sel  = 1'b1;
    bus_we   = 1'b0;
    bus_addr = 3'd3;
    tick();
    chk("resp_before_reset", {31'd0, bus_ready}, 32'd1);
    bus_sel = 1'b0;
    #1;
    reset = 1'b1;
    model_reset();
    #1;
    chk("resp_reset_ready", {31'd0, bus_ready}, 32'd0);
    chk("resp_reset_rdata", bus_rdata, 32'd0);
    chk("resp_reset_INT", {31'd0, INT}, 32'd0);
    wait_cycles(2);
    reset = 1'b0;
    for (int n = 0; n < 3; n++) begin
      tick();
      chk("post_reset_no_ready", {31'd0, bus_ready}, 32'd0);
    end

    // Randomized traffic checked every cycle by the model.
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 2) == 0) begin
        int b;
        b = $urandom_range(0, 7);
        irq_src[b] = ~irq_src[b];
      end
      bus_sel   = ($urandom_range(0, 2) != 0);
      bus_we    = $urandom_range(0, 1) == 1;
      bus_addr  = ($urandom_range(0, 3) == 0) ? 3'd2 : 3'($urandom_range(0, 7));
      bus_wdata = $urandom;
      tick();
    end
    bus_sel = 1'b0;
    wait_cycles(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/int_ctrl.md
INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 SHALL have parameter NUM_SRC, default 8, number of interrupt sources, legal range 1..8.
REQ-002 SHALL have port clk, input, 1, single system clock; all state on rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-004 SHALL have port irq_src, input, NUM_SRC, asynchronous peripheral interrupt lines, rising-edge significant.
REQ-005 SHALL have port bus_sel, input, 1, CPU access strobe for this block's address window.
REQ-006 SHALL have port bus_we, input, 1, 1=write, 0=read; sampled with bus_sel.
REQ-007 SHALL have port bus_addr, input, 3, word offset (byte address bits [4:2]).
REQ-008 SHALL have port bus_wdata, input, 32, write data.
REQ-009 SHALL have port bus_rdata, output, 32, read data; valid while bus_ready=1, else 0.
REQ-010 SHALL have port bus_ready, output, 1, one-cycle completion pulse; drives the CPU's MIO_ready path.
REQ-011 SHALL have port INT, output, 1, registered interrupt request to the CPU.

Function
REQ-012 SHALL detect a rising edge per source from the sampled irq_src versus its previous sample, setting pending[i].
REQ-013 SHALL implement registers: 0 PENDING (read; write-1-to-clear), 1 MASK (RW, 1=enabled), 2 CLAIM (read-only), 3 CTRL (bit0 GIE, RW), 4 RAW (read sampled irq_src); other offsets read 0, writes ignored.
REQ-014 SHALL zero-extend all registers narrower than 32 bits; write bits above NUM_SRC are ignored.
REQ-015 SHALL use a bus FSM with states IDLE and RESP: IDLE plus bus_sel goes to RESP, performing the write or latching read data; RESP asserts bus_ready for exactly one cycle and returns to IDLE.
REQ-016 SHALL ignore bus_sel while in RESP; a back-to-back access completes every 2 cycles.
REQ-017 SHALL, on a CLAIM read, return {1'b1, 27'b0, id[3:0]} for the lowest-index pending&MASK source and clear that pending bit in the same cycle.
REQ-018 SHALL, on a CLAIM read with no pending&MASK bit, return 0x0000_0000 and change no state.
REQ-019 SHALL give set priority: an edge arriving in the same cycle as a W1C or claim clear of the same bit leaves that bit set.
REQ-020 SHALL register INT = GIE & |(pending & MASK); it follows any state change with 1 cycle of latency.
REQ-021 SHALL latch masked-source edges in pending without asserting INT; unmasking a pending source raises INT one cycle later.

Reset
REQ-022 SHALL, on reset assertion, asynchronously clear pending, MASK, GIE, edge-history and synchronizer flops, and set FSM to IDLE, bus_ready=0, bus_rdata=0, INT=0.
REQ-023 SHALL abandon any in-flight access on reset mid-RESP; no bus_ready pulse is issued for it.
REQ-024 SHALL not produce a spurious edge at reset deassertion, because edge history resets to 0 and a line held high yields one edge only after the first post-reset sample.

Configuration
REQ-025 SHALL, with macro INTC_SYNC_EN defined, pass irq_src through a 2-flop synchronizer before edge detection, giving 3 cycles from input edge to pending and 4 to INT.
REQ-026 SHALL, without INTC_SYNC_EN, sample irq_src in a single flop, giving 1 cycle to pending and 2 to INT; irq_src is then required to be synchronous to clk.

Structure
REQ-027 SHALL take register offsets (PENDING=0, MASK=1, CLAIM=2, CTRL=3, RAW=4), the CLAIM valid-bit position (31) and the FSM state enum from shared package intc_pkg.
REQ-028 SHALL place the lowest-index-first priority encoder (NUM_SRC-bit input; outputs valid and id) in sub-module intc_prio_enc.

Verification
REQ-029 SHALL verify reset: hold irq_src=0xFF through reset release; INT=0, PENDING reads 0x00, and no pending bit sets until the lines toggle.
REQ-030 SHALL verify edge and priority: MASK=0x0C, GIE=1, pulse irq_src[3] then [2]; INT rises, CLAIM returns 0x8000_0002 then 0x8000_0003, then 0x0000_0000, and INT falls 1 cycle after the second claim.
REQ-031 SHALL verify masking: MASK=0x00, edge on src 5; PENDING=0x20 and INT=0; write MASK=0x20; INT=1 one cycle later.
REQ-032 SHALL verify collision: write PENDING=0x01 (W1C) in the same cycle an edge on src 0 reaches pending; PENDING still reads 0x01.
REQ-033 SHALL verify the handshake: bus_sel held high for 6 cycles produces bus_ready pulses on cycles 2, 4 and 6 only, each 1 cycle wide; bus_rdata is 0 outside the pulses.
REQ-034 SHALL verify configuration: the edge-to-INT latency is 4 cycles with INTC_SYNC_EN and 2 without; reset asserted during RESP yields no bus_ready pulse.
